// File: rtl/bcd_digit_feeder_pkg.sv
// Shared definitions for the BCD digit feeder.
//   state_t        : controller states (IDLE, CONV, LATCH), 2-bit encoding
//   NUM_DIGITS     : number of BCD digits produced (4)
//   BCD_MAX        : largest value that fits in four digits (9999)
//   ITERATIONS     : shift-add-3 iterations, one per input bit (14)
//   compute_show() : per-digit show flags with optional leading-zero blanking
package bcd_digit_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CONV  = 2'd1,
    ST_LATCH = 2'd2
  } state_t;

  localparam int NUM_DIGITS = 4;
  localparam int BCD_MAX    = 9999;
  localparam int ITERATIONS = 14;

  // Returns {show1, show2, show3, show4}. The units digit is always shown so
  // a value of zero still displays a single "0".
  function automatic logic [3:0] compute_show(input logic [3:0] d1,
                                              input logic [3:0] d2,
                                              input logic [3:0] d3,
                                              input logic       blank);
    logic [3:0] show;
    if (blank) begin
      show[3] = (d1 != 4'd0);
      show[2] = (d2 != 4'd0) | show[3];
      show[1] = (d3 != 4'd0) | show[2];
      show[0] = 1'b1;
    end else begin
      show = 4'b1111;
    end
    return show;
  endfunction

endpackage

// File: rtl/bcd_digit_feeder_add3.sv
// Double-dabble correction cell: a BCD nibble of 5 or more gets 3 added so
// that the following left shift carries correctly into the next decade.
//   nibble   : current BCD digit (0..9)
//   adjusted : corrected digit, ready to be shifted
module bcd_add3 (
  input  logic [3:0] nibble,
  output logic [3:0] adjusted
);

  assign adjusted = (nibble >= 4'd5) ? nibble + 4'd3 : nibble;

endmodule

// File: rtl/bcd_digit_feeder.sv
// Sequential binary-to-BCD converter feeding a 4-digit 7-segment mux driver.
// A request captures i_value (saturated to 9999), runs 14 shift-add-3
// iterations, then registers all four digits and show flags in a single
// cycle so the display never sees a partial result.
//   clk            : system clock, rising edge
//   rst            : asynchronous reset, active low
//   i_value        : unsigned value to convert
//   i_start        : conversion request, honoured only while idle
//   o_digit1..4    : thousands .. units BCD digits (held between conversions)
//   o_show_digit1..4 : digit-enable flags for the display driver
//   o_busy         : conversion in progress
//   o_done         : one-cycle pulse, outputs were just updated
//   o_overflow     : last converted value was saturated to 9999
module bcd_digit_feeder
  import bcd_digit_feeder_pkg::*;
#(
  parameter int WIDTH         = 14,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_value,
  input  logic             i_start,
  output logic [3:0]       o_digit1,
  output logic [3:0]       o_digit2,
  output logic [3:0]       o_digit3,
  output logic [3:0]       o_digit4,
  output logic             o_show_digit1,
  output logic             o_show_digit2,
  output logic             o_show_digit3,
  output logic             o_show_digit4,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_overflow
);

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q;
  logic [WIDTH-1:0]        bin_q;
  logic [4*NUM_DIGITS-1:0] bcd_q;
  logic [4*NUM_DIGITS-1:0] bcd_adj;
  logic                    ovf_q;
  logic [3:0]              digit1_q, digit2_q, digit3_q, digit4_q;
  logic [3:0]              show_q;
  logic                    done_q;
  logic                    overflow_q;
  logic [3:0]              show_new;

  // Correction of all nibbles happens in parallel ahead of the shift.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .nibble   (bcd_q[4*g +: 4]),
      .adjusted (bcd_adj[4*g +: 4])
    );
  end

  assign show_new = compute_show(bcd_q[15:12], bcd_q[11:8], bcd_q[7:4],
                                 BLANK_LEADING);

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (i_start) state_d = ST_CONV;
      ST_CONV:  if (cnt_q == 4'(ITERATIONS - 1)) state_d = ST_LATCH;
      ST_LATCH: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge value of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Iteration datapath: capture, then shift {bcd, bin} left once per cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      bin_q <= '0;
      bcd_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            if (i_value > WIDTH'(BCD_MAX)) begin
              bin_q <= WIDTH'(BCD_MAX);
              ovf_q <= 1'b1;
            end else begin
              bin_q <= i_value;
              ovf_q <= 1'b0;
            end
            bcd_q <= '0;
            cnt_q <= '0;
          end
        end
        ST_CONV: begin
          {bcd_q, bin_q} <= {bcd_adj[4*NUM_DIGITS-2:0], bin_q, 1'b0};
          cnt_q          <= cnt_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Display-facing registers only move in LATCH; done is a one-cycle pulse
  // in the cycle after the LATCH edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digit1_q   <= '0;
      digit2_q   <= '0;
      digit3_q   <= '0;
      digit4_q   <= '0;
      show_q     <= 4'b0001;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= (state_q == ST_LATCH);
      if (state_q == ST_LATCH) begin
        digit1_q   <= bcd_q[15:12];
        digit2_q   <= bcd_q[11:8];
        digit3_q   <= bcd_q[7:4];
        digit4_q   <= bcd_q[3:0];
        show_q     <= show_new;
        overflow_q <= ovf_q;
      end
    end
  end

  assign o_digit1      = digit1_q;
  assign o_digit2      = digit2_q;
  assign o_digit3      = digit3_q;
  assign o_digit4      = digit4_q;
  assign o_show_digit1 = show_q[3];
  assign o_show_digit2 = show_q[2];
  assign o_show_digit3 = show_q[1];
  assign o_show_digit4 = show_q[0];
  assign o_busy        = (state_q != ST_IDLE);
  assign o_done        = done_q;
  assign o_overflow    = overflow_q;

endmodule

// File: tb/tb_bcd_digit_feeder.sv
// Directed testbench for bcd_digit_feeder: a table of conversions with
// hand-computed digits/show flags/overflow, plus hand-written sequences for
// reset idle, ignored mid-conversion start, back-to-back start and reset
// during a conversion. A second instance built without leading-zero
// blanking shares the inputs.
module tb_bcd_digit_feeder;

  logic        clk;
  logic        rst;
  logic [13:0] i_value;
  logic        i_start;

  logic [3:0] d1, d2, d3, d4;
  logic       s1, s2, s3, s4;
  logic       busy, done, ovf;

  logic [3:0] nb_d1, nb_d2, nb_d3, nb_d4;
  logic       nb_s1, nb_s2, nb_s3, nb_s4;
  logic       nb_busy, nb_done, nb_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_digit_feeder #(.WIDTH(14), .BLANK_LEADING(1'b1)) dut (
    .clk(clk), .rst(rst), .i_value(i_value), .i_start(i_start),
    .o_digit1(d1), .o_digit2(d2), .o_digit3(d3), .o_digit4(d4),
    .o_show_digit1(s1), .o_show_digit2(s2), .o_show_digit3(s3),
    .o_show_digit4(s4), .o_busy(busy), .o_done(done), .o_overflow(ovf)
  );

  bcd_digit_feeder #(.WIDTH(14), .BLANK_LEADING(1'b0)) dut_nb (
    .clk(clk), .rst(rst), .i_value(i_value), .i_start(i_start),
    .o_digit1(nb_d1), .o_digit2(nb_d2), .o_digit3(nb_d3), .o_digit4(nb_d4),
    .o_show_digit1(nb_s1), .o_show_digit2(nb_s2), .o_show_digit3(nb_s3),
    .o_show_digit4(nb_s4), .o_busy(nb_busy), .o_done(nb_done),
    .o_overflow(nb_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] value;
    logic [15:0] digits;  // {d1,d2,d3,d4}
    logic [3:0]  show;    // {s1,s2,s3,s4}
    logic        ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Watches 20 cycles after the start edge, sampling on falling edges.
  // lat is the number of rising edges from the start edge to the cycle in
  // which done is first seen.
  task automatic observe(output int busy_cnt, output int done_cnt,
                         output int lat);
    busy_cnt = 0;
    done_cnt = 0;
    lat      = -1;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (lat < 0) lat = cyc - 1;
      end
    end
  endtask

  // i_start is already asserted; let the next rising edge take it.
  task automatic fire(output int busy_cnt, output int done_cnt,
                      output int lat);
    @(posedge clk);
    #1 i_start = 1'b0;
    observe(busy_cnt, done_cnt, lat);
  endtask

  task automatic launch(input logic [13:0] value, output int busy_cnt,
                        output int done_cnt, output int lat);
    @(negedge clk);
    i_value = value;
    i_start = 1'b1;
    fire(busy_cnt, done_cnt, lat);
  endtask

  initial begin
    int bc, dc, lat;

    vecs[0] = '{14'd1234,  16'h1234, 4'b1111, 1'b0};
    vecs[1] = '{14'd7,     16'h0007, 4'b0001, 1'b0};
    vecs[2] = '{14'd0,     16'h0000, 4'b0001, 1'b0};
    vecs[3] = '{14'd42,    16'h0042, 4'b0011, 1'b0};
    vecs[4] = '{14'd305,   16'h0305, 4'b0111, 1'b0};
    vecs[5] = '{14'd1000,  16'h1000, 4'b1111, 1'b0};
    vecs[6] = '{14'd16383, 16'h9999, 4'b1111, 1'b1};
    vecs[7] = '{14'd9999,  16'h9999, 4'b1111, 1'b0};
    vecs[8] = '{14'd10000, 16'h9999, 4'b1111, 1'b1};
    vecs[9] = '{14'd8765,  16'h8765, 4'b1111, 1'b0};

    // Reset and idle.
    rst     = 1'b0;
    i_start = 1'b0;
    i_value = '0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    dc  = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) dc++;
    end
    check("idle_done_count", dc, 0);
    check("reset_digits", {d1, d2, d3, d4}, 16'h0000);
    check("reset_show", {s1, s2, s3, s4}, 4'b0001);
    check("reset_busy", busy, 1'b0);
    check("reset_ovf", ovf, 1'b0);

    // Table-driven conversions.
    for (int v = 0; v < 10; v++) begin
      launch(vecs[v].value, bc, dc, lat);
      check($sformatf("v%0d_digits", v), {d1, d2, d3, d4}, vecs[v].digits);
      check($sformatf("v%0d_show", v), {s1, s2, s3, s4}, vecs[v].show);
      check($sformatf("v%0d_ovf", v), ovf, vecs[v].ovf);
      check($sformatf("v%0d_busy_cycles", v), bc, 15);
      check($sformatf("v%0d_done_count", v), dc, 1);
      check($sformatf("v%0d_latency", v), lat, 15);
      check($sformatf("v%0d_nb_digits", v), {nb_d1, nb_d2, nb_d3, nb_d4},
            vecs[v].digits);
      check($sformatf("v%0d_nb_show", v), {nb_s1, nb_s2, nb_s3, nb_s4},
            4'b1111);
    end

    // Start 5678, second start at clock 5 ignored, restart on the first
    // idle edge after done.
    @(negedge clk);
    i_value = 14'd5678;
    i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    dc = 0;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      @(negedge clk);
      if (done) dc++;
      if (cyc == 5) begin
        i_value = 14'd1111;
        i_start = 1'b1;
      end else begin
        i_start = 1'b0;
      end
    end
    check("ovl_done_count", dc, 1);
    check("ovl_done_at_15", done, 1'b1);
    check("ovl_digits", {d1, d2, d3, d4}, 16'h5678);
    i_value = 14'd1111;
    i_start = 1'b1;
    fire(bc, dc, lat);
    check("b2b_digits", {d1, d2, d3, d4}, 16'h1111);
    check("b2b_done_count", dc, 1);
    check("b2b_latency", lat, 15);

    // Reset in the middle of a conversion.
    @(negedge clk);
    i_value = 14'd4321;
    i_start = 1'b1;
    @(posedge clk);
    #1 i_start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_mid_digits", {d1, d2, d3, d4}, 16'h0000);
    check("rst_mid_show", {s1, s2, s3, s4}, 4'b0001);
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_ovf", ovf, 1'b0);
    dc = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) dc++;
    end
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done || busy) dc++;
    end
    check("rst_mid_no_done", dc, 0);
    check("rst_mid_digits_held", {d1, d2, d3, d4}, 16'h0000);
    launch(14'd9, bc, dc, lat);
    check("post_rst_digits", {d1, d2, d3, d4}, 16'h0009);
    check("post_rst_show", {s1, s2, s3, s4}, 4'b0001);
    check("post_rst_latency", lat, 15);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_digit_feeder.md
Name: bcd_digit_feeder

Overview:
- Sequential binary-to-BCD converter that sits directly upstream of the 4-digit 7-segment mux driver.
- Converts a 14-bit unsigned value (0..9999) into four BCD digits using iterative shift-add-3 (double dabble).
- Produces per-digit show flags with optional leading-zero blanking.
- Outputs are held stable between conversions, so the display never shows partial results.

Parameters:
- WIDTH, 14: input value width; fixed to cover 0..9999.
- BLANK_LEADING, 1: 1 = suppress leading zeros via show flags; 0 = all show flags always 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- i_value  in  14  unsigned binary value to convert.
- i_start  in  1  conversion request; sampled only in IDLE.
- o_digit1  out  4  thousands digit, leftmost.
- o_digit2  out  4  hundreds digit.
- o_digit3  out  4  tens digit.
- o_digit4  out  4  units digit, rightmost.
- o_show_digit1..o_show_digit4  out  1 each  digit-enable flags for the display driver.
- o_busy  out  1  conversion in progress.
- o_done  out  1  one-cycle pulse; outputs were updated this cycle.
- o_overflow  out  1  last converted value exceeded 9999 (saturated); held until the next completed conversion.

Behaviour:
- Reset (rst=0, async):
  - state IDLE; o_digit1..4 = 0; o_show_digit1..3 = 0; o_show_digit4 = 1 (display shows "0").
  - o_busy = 0, o_done = 0, o_overflow = 0.
  - Iteration counter and scratch register = 0.
- States: IDLE, CONV, LATCH.
- IDLE:
  - On rising edge E0 with i_start=1, capture i_value.
  - If i_value > 9999, capture 9999 and set an internal ovf flag.
  - Clear the 16-bit BCD scratch, set iteration count = 0, go to CONV, o_busy=1.
- CONV:
  - Each edge E1..E14 performs one iteration:
    - For each BCD nibble >= 5, add 3 (all nibbles in parallel, combinational).
    - Shift {bcd, bin} left by 1, MSB of bin entering bcd bit 0.
  - After the 14th iteration (count = 13 at the edge), go to LATCH.
- LATCH (edge E15):
  - Register digits from scratch; compute show flags; o_overflow = ovf.
  - o_done = 1 for exactly this one cycle; o_busy = 0; next state IDLE.
- Latency: o_done visible in the cycle after E15, i.e. 15 clocks after the start edge. Max throughput is one conversion per 16 clocks.
- o_busy is high from after E0 through the cycle ending at E15.
- i_start in CONV or LATCH is ignored (not queued). A new start is accepted at the first IDLE edge.
- i_value changes after E0 do not affect the running conversion.
- Digit and show outputs change only at LATCH and hold otherwise.
- Show flags, BLANK_LEADING=1:
  - show4 = 1.
  - show3 = (d3 != 0) | (d2 != 0) | (d1 != 0).
  - show2 = (d2 != 0) | (d1 != 0).
  - show1 = (d1 != 0).
- Show flags, BLANK_LEADING=0: all = 1.
- Reset asserted mid-conversion:
  - Immediate return to the reset values above. No o_done; the previous digits are lost.
  - Conversion resumes only on a new i_start after reset is released.
- Arithmetic: the scratch nibbles never exceed 9 after any iteration for inputs <= 9999; no carry out of the 16-bit scratch.

Decomposition:
- Shared package holds:
  - state encoding constants (IDLE/CONV/LATCH, 2 bits)
  - NUM_DIGITS = 4
  - BCD_MAX = 9999
  - ITERATIONS = 14
- One natural sub-module: bcd_add3, a 4-bit combinational cell (out = in >= 5 ? in + 3 : in). It is instantiated 4 times inside the iteration datapath.
- Counter, FSM and output registers stay in the top module.

Test Plan:
- Reset, then idle 20 cycles -> digits 0,0,0,0; show 0,0,0,1; o_busy=0; o_done never pulses; o_overflow=0.
- i_value=1234, i_start for 1 cycle -> o_busy high 15 cycles; o_done one pulse 15 clocks after start; digits 1,2,3,4; show 1,1,1,1; o_overflow=0.
- i_value=7 then i_value=0 (separate runs):
  - 7 -> digits 0,0,0,7; show 0,0,0,1.
  - 0 -> digits 0,0,0,0; show 0,0,0,1.
  - Rebuild with BLANK_LEADING=0, value 42 -> digits 0,0,4,2; show 1,1,1,1.
- i_value=16383 -> digits 9,9,9,9; o_overflow=1. Next conversion of 9999 -> same digits, o_overflow=0. Next conversion of 10000 -> 9,9,9,9, o_overflow=1.
- Start 5678, pulse i_start again at clock 5 with i_value=1111 -> second start ignored; single o_done; digits 5,6,7,8. A start on the first IDLE cycle after done is accepted (1111 converts correctly).
- Start 4321, assert rst at clock 8 for 2 cycles -> outputs return to reset values immediately; no o_done. Fresh start with 9 -> digits 0,0,0,9 after 15 clocks.
